// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared constants and next-address source encoding for the program sequencer
package ps_pkg;
    localparam int STACK_DEPTH = 4;
    localparam int ADDR_W      = 8;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_RET,
        SRC_CALL,
        SRC_JMP,
        SRC_JNZ,
        SRC_INC
    } next_src_t;
endpackage

// File: rtl/ps_return_stack.sv
// rtl/ps_return_stack.sv - LIFO of return addresses with depth count, full/empty and zero-on-empty top
module ps_return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  push_data_i,
    output logic [W-1:0]  top_o,
    output logic [DW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [DW-1:0] depth_q;

    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    // Slots above depth are stale; only the live top is ever exposed.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (depth_q == DW'(i)) begin
                    mem_q[i] <= push_data_i;
                end
            end
            depth_q <= depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - DW'(1);
        end
    end
endmodule

// File: rtl/program_sequencer_stack.sv
// rtl/program_sequencer_stack.sv - next-address sequencer with jump/branch and a call/return stack
module program_sequencer_stack
    import ps_pkg::*;
#(
    parameter int  STACK_DEPTH = ps_pkg::STACK_DEPTH,
    parameter int  ADDR_W      = ps_pkg::ADDR_W,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jmp,
    input  logic               jmp_nz,
    input  logic               zero_flag,
    input  logic               call,
    input  logic               ret,
    input  logic [3:0]         jmp_addr,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [DEPTH_W-1:0] stack_depth,
    output logic               stack_err,
    output logic [DEPTH_W+4:0] from_PS
);
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  stk_top;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full;
    logic               stk_empty;
    logic               push;
    logic               pop;
    logic               err_q;
    logic               err_d;
    next_src_t          src;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign target = {pc_q[ADDR_W-1:4], jmp_addr};

    // A failed call/ret still advances sequentially and only marks the sticky error.
    always_comb begin
        src   = SRC_INC;
        push  = 1'b0;
        pop   = 1'b0;
        err_d = err_q;
        if (reset) begin
            src = SRC_RESET;
        end else if (ret) begin
            if (!stk_empty) begin
                src = SRC_RET;
                pop = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (call) begin
            if (!stk_full) begin
                src  = SRC_CALL;
                push = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (jmp) begin
            src = SRC_JMP;
        end else if (jmp_nz && !zero_flag) begin
            src = SRC_JNZ;
        end
    end

    always_comb begin
        pm_addr = pc_inc;
        case (src)
            SRC_RESET: pm_addr = '0;
            SRC_RET:   pm_addr = stk_top;
            SRC_CALL,
            SRC_JMP,
            SRC_JNZ:   pm_addr = target;
            default:   pm_addr = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pm_addr;
            err_q <= err_d;
        end
    end

    ps_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W),
        .DW    (DEPTH_W)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .top_o       (stk_top),
        .depth_o     (stk_depth),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    assign pc          = pc_q;
    assign stack_depth = stk_depth;
    assign stack_err   = err_q;
    assign from_PS     = {err_q, stk_depth, stk_top[3:0]};
endmodule

// File: doc/program_sequencer_stack.md
PROGRAM_SEQUENCER_STACK -- requirements
Module: program_sequencer_stack

Interface
REQ-001 SHALL use clock clk and reset reset (synchronous, active-high); all state changes on rising clk only.
REQ-002 SHALL provide ports, one per line (name  direction  width  meaning):
- clk  in  1  1 MHz system clock
- reset  in  1  synchronous active-high reset
- jmp  in  1  unconditional jump request from instruction decoder
- jmp_nz  in  1  jump request taken only when zero_flag==0
- zero_flag  in  1  zero flag from computational unit
- call  in  1  subroutine call request
- ret  in  1  subroutine return request
- jmp_addr  in  4  target low nibble for jmp/jmp_nz/call
- pm_addr  out  8  next program-memory address (combinational)
- pc  out  8  registered current address
- stack_depth  out  3  valid return-stack entries, 0..4
- stack_err  out  1  sticky overflow/underflow flag
- from_PS  out  8  debug byte to test scrambler
REQ-003 SHALL define parameter STACK_DEPTH, default 4, return-stack entry count.
REQ-004 SHALL define parameter ADDR_W, default 8, address width.

Function
REQ-005 pm_addr SHALL be combinational; pc SHALL register pm_addr every clk (pc lags pm_addr by one cycle).
REQ-006 Branch target SHALL be {pc[7:4], jmp_addr}.
REQ-007 pm_addr source priority SHALL be: reset -> 8'h00; ret; call; jmp; jmp_nz with zero_flag==0; else pc+1.
REQ-008 pc+1 SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-009 Valid call (depth<4): pm_addr = target; push pc+1 (wrapped); depth +1 at clk.
REQ-010 Valid ret (depth>0): pm_addr = top entry; pop; depth -1 at clk.
REQ-011 call at depth==4 (overflow): no push, pm_addr = pc+1, stack_err set at clk.
REQ-012 ret at depth==0 (underflow): no pop, pm_addr = pc+1, stack_err set at clk.
REQ-013 Simultaneous ret and call: ret served per REQ-007, call dropped, stack_err unchanged by the call.
REQ-014 jmp_nz with zero_flag==1 SHALL yield pc+1.
REQ-015 stack_err SHALL remain 1 until reset.
REQ-016 from_PS SHALL equal {stack_err, stack_depth, top_entry[3:0]}; top_entry reads 4'h0 when depth==0.
REQ-017 Stack contents beyond depth SHALL be don't-care, never driven onto pm_addr.

Reset
REQ-018 While reset==1: pm_addr = 8'h00 combinationally; at clk pc <= 8'h00, stack_depth <= 0, stack_err <= 0, entries cleared to 8'h00.
REQ-019 Reset SHALL override all requests in the same cycle, including mid call/ret sequences; first post-reset fetch is 8'h00, then 8'h01.
REQ-020 Reset pulses as short as one clk (0.1 us glitch not sampled) SHALL be handled only on sampled edges.

Structure
REQ-021 Package ps_pkg SHALL hold STACK_DEPTH, ADDR_W, and enum next_src_t {SRC_RESET, SRC_RET, SRC_CALL, SRC_JMP, SRC_JNZ, SRC_INC}.
REQ-022 LIFO SHALL be sub-module ps_return_stack (push, pop, top, depth, full, empty); priority/next-address logic stays in top.

Verification
REQ-023 Reset then 4 free-run clks -> pm_addr 00,01,02,03,04; pc trails by one; from_PS 8'h00.
REQ-024 pc=8'h35, call, jmp_addr=4'hA -> pm_addr 8'h3A; next cycle depth=1, top=8'h36, from_PS 8'h16; later ret -> pm_addr 8'h36, depth 0.
REQ-025 Five nested calls from depth 0 -> first four push, fifth gives pm_addr=pc+1, stack_err=1, depth stays 4, from_PS[7]=1.
REQ-026 ret at depth 0 with pc=8'h10 -> pm_addr 8'h11, stack_err=1; persists through 10 further cycles until reset.
REQ-027 pc=8'hFF free-run -> pm_addr 8'h00; jmp_nz jmp_addr=4'h3 with zero_flag=1 at pc=8'h20 -> 8'h21, with zero_flag=0 -> 8'h23.
REQ-028 call+ret together at depth 2 and reset asserted mid-sequence -> ret served, depth 1; reset cycle -> pm_addr 8'h00, depth 0, stack_err 0.
